// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, defaults and payload types for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

    // Register-file geometry shared with the rest of the core.
    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    // Arbiter defaults.
    localparam int unsigned WPORT_DEPTH      = 2;
    localparam int unsigned WPORT_STARVE_MAX = 4;

    // Reset level for this block: rst is active-low.
    localparam logic RST_ENABLE = 1'b0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    // One queued B result; live=0 means superseded by a younger A write.
    typedef struct packed {
        logic      live;
        reg_addr_t addr;
        reg_data_t data;
    } wport_entry_t;

endpackage

// File: rtl/regfile_wport_arbiter_queue.sv
// B-result queue: FIFO storage with per-entry live bit and an address-match
// CAM used both for killing superseded entries and for decode busy lookups.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   push/push_addr/push_data/push_dead  enqueue one entry (dead = stored killed)
//   pop                 retire the head entry
//   kill/kill_addr      clear live on every stored entry matching kill_addr
//   raddr1/raddr2       lookup addresses; match1/match2 = a live entry matches
//   count               occupancy
//   head_live/head_addr/head_data  head entry view
module regfile_wport_arbiter_queue
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WPORT_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  reg_addr_t     push_addr,
    input  reg_data_t     push_data,
    input  logic          push_dead,
    input  logic          pop,
    input  logic          kill,
    input  reg_addr_t     kill_addr,
    input  reg_addr_t     raddr1,
    input  reg_addr_t     raddr2,
    output logic [CW-1:0] count,
    output logic          head_live,
    output reg_addr_t     head_addr,
    output reg_data_t     head_data,
    output logic          match1,
    output logic          match2
);

    wport_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // Storage and pointers. Live is cleared on pop so a set live bit always
    // marks an occupied slot.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill && (mem_q[i].addr == kill_addr)) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem_q[head_q].live <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
            if (push) begin
                mem_q[tail_q] <= '{live: !push_dead, addr: push_addr, data: push_data};
                tail_q        <= tail_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // CAM lookup for decode busy.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem_q[i].live && (mem_q[i].addr == raddr1)) match1 = 1'b1;
            if (mem_q[i].live && (mem_q[i].addr == raddr2)) match2 = 1'b1;
        end
    end

    assign count     = count_q;
    assign head_live = mem_q[head_q].live;
    assign head_addr = mem_q[head_q].addr;
    assign head_data = mem_q[head_q].data;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register file's single write port between pipeline writeback (A,
// never stalls) and a multi-cycle unit (B, valid/ready). B results are queued
// and drain when A leaves the port idle; a starvation counter forces a drain
// by raising stall_req. Queued B results are always older than A writes, so an
// A write kills any queued entry with the same target.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   a_we/a_waddr/a_wdata       pipeline writeback request
//   b_valid/b_ready            B handshake (b_ready = queue not full)
//   b_waddr/b_wdata            B result
//   raddr1/raddr2, busy1/busy2 decode lookup: live pending B write to raddr
//   we/waddr/wdata             regfile write port (combinational, 0 latency)
//   stall_req                  registered: pipeline must hold a_we=0 this cycle
//   proto_err                  sticky: a_we seen while stall_req=1
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = WPORT_DEPTH,
    parameter int unsigned STARVE_MAX = WPORT_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [REG_AW-1:0] a_waddr,
    input  logic [REG_DW-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_waddr,
    input  logic [REG_DW-1:0] b_wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [REG_DW-1:0] wdata,
    output logic              stall_req,
    output logic              proto_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic          rst_act;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;
    logic          head_live;
    reg_addr_t     head_addr;
    reg_data_t     head_data;
    logic          match1;
    logic          match2;
    logic          a_req;
    logic          a_grant;
    logic          pop;
    logic          b_acc;
    logic          push;
    logic          push_dead;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_nxt;
    logic          stall_nxt;

    assign rst_act   = (rst == RST_ENABLE);
    assign q_empty   = (q_count == '0);
    assign q_full    = (q_count == CW'(DEPTH));
    assign a_req     = a_we && (a_waddr != '0);
    assign b_ready   = !rst_act && !q_full;
    assign b_acc     = b_valid && b_ready;
    assign push      = b_acc && (b_waddr != '0);
    assign push_dead = a_grant && (a_waddr == b_waddr);

    regfile_wport_arbiter_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (b_waddr),
        .push_data (b_wdata),
        .push_dead (push_dead),
        .pop       (pop),
        .kill      (a_grant),
        .kill_addr (a_waddr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .count     (q_count),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .match1    (match1),
        .match2    (match2)
    );

    // Write-port grant: forced drain, then A, then opportunistic drain.
    // A popped dead head is discarded with we=0.
    always_comb begin
        a_grant = 1'b0;
        pop     = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        if (!rst_act) begin
            if (stall_req) begin
                pop = !q_empty;
            end else if (a_req) begin
                a_grant = 1'b1;
                we      = 1'b1;
                waddr   = a_waddr;
                wdata   = a_wdata;
            end else begin
                pop = !q_empty;
            end
            if (pop && head_live) begin
                we    = 1'b1;
                waddr = head_addr;
                wdata = head_data;
            end
        end
    end

    // Busy: a live queued target, or an accept this cycle not killed by A.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!rst_act && (raddr1 != '0)) begin
            busy1 = match1 || (b_acc && (b_waddr == raddr1) && !(a_grant && (a_waddr == raddr1)));
        end
        if (!rst_act && (raddr2 != '0)) begin
            busy2 = match2 || (b_acc && (b_waddr == raddr2) && !(a_grant && (a_waddr == raddr2)));
        end
    end

    // Starvation count and the stall request it raises for one cycle.
    always_comb begin
        starve_nxt = starve_q;
        if (q_empty || pop) begin
            starve_nxt = '0;
        end else if (a_grant && head_live && (starve_q != SW'(STARVE_MAX))) begin
            starve_nxt = starve_q + 1'b1;
        end
        stall_nxt = !stall_req && (starve_nxt == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            starve_q  <= '0;
            stall_req <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            starve_q  <= starve_nxt;
            stall_req <= stall_nxt;
            if (stall_req && a_we) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
